// File: rtl/ref_sig_gen_pkg.sv
// ref_sig_gen_pkg: shared FSM states, default widths and LFSR constants for the
// reference signal generator.
package ref_sig_gen_pkg;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_STEP_W = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEPPING = 2'd2
  } state_t;

endpackage

// File: rtl/ref_sig_gen_lfsr16.sv
// lfsr16: 16-bit maximal-length Fibonacci LFSR used as a jitter source.
// Only built when REF_SIG_GEN_JITTER_EN is defined.
`ifdef REF_SIG_GEN_JITTER_EN
module lfsr16
  import ref_sig_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] lfsr_r;

  // shift once per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (advance) begin
      lfsr_r <= {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign state = lfsr_r;

endmodule
`endif

// File: rtl/ref_sig_gen.sv
// ref_sig_gen: phase-accumulator square-wave reference with a programmable
// sequence of phase steps. Optional LFSR jitter under REF_SIG_GEN_JITTER_EN.
module ref_sig_gen
  import ref_sig_gen_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfgValid,
  output logic              cfgReady,
  input  logic [ACC_W-1:0]  cfgFtw,
  input  logic [ACC_W-1:0]  cfgPhaseStep,
  input  logic [STEP_W-1:0] cfgSteps,
  output logic              sigOut,
  output logic              stepEvent,
  output logic              busy
);

  state_t            state_r, nextState_s;
  logic [1:0]        rstSync_r;
  logic [ACC_W-1:0]  acc_r, ftw_r, phaseStep_r, ftwEff_s, accNext_s;
  logic [ACC_W:0]    sum_s;
  logic [STEP_W-1:0] stepCnt_r, stepCntNext_s;
  logic              advance_s, accept_s, stepNow_s;
  logic              sigOut_r, stepEvent_r, busy_r, cfgReady_r;

  // release synchroniser: accumulator stays parked until two edges after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstSync_r <= 2'b00;
    end else begin
      rstSync_r <= {rstSync_r[0], 1'b1};
    end
  end

  assign advance_s = enable && rstSync_r[1];
  assign accept_s  = cfgValid && cfgReady_r;

`ifdef REF_SIG_GEN_JITTER_EN
  logic [15:0] lfsr_s;

  lfsr16 uLfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (advance_s),
    .state   (lfsr_s)
  );

  // jitter is suppressed at ftw==0 so a stopped generator stays frozen
  always_comb begin
    if (ftw_r != {ACC_W{1'b0}}) begin
      ftwEff_s = ftw_r + ACC_W'(lfsr_s[3:0]);
    end else begin
      ftwEff_s = ftw_r;
    end
  end
`else
  assign ftwEff_s = ftw_r;
`endif

  assign sum_s = {1'b0, acc_r} + {1'b0, ftwEff_s};

  // next-state, accumulator and step-count logic
  always_comb begin
    nextState_s   = state_r;
    stepCntNext_s = stepCnt_r;
    stepNow_s     = 1'b0;
    accNext_s     = acc_r;
    if (advance_s) begin
      stepNow_s = (state_r == ST_STEPPING) && sum_s[ACC_W] &&
                  (stepCnt_r != {STEP_W{1'b0}});
      if (stepNow_s) begin
        accNext_s     = sum_s[ACC_W-1:0] + phaseStep_r;
        stepCntNext_s = stepCnt_r - STEP_W'(1);
      end else begin
        accNext_s     = sum_s[ACC_W-1:0];
      end
    end else begin
      accNext_s = acc_r;
    end
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (accept_s) begin
          if (cfgSteps != {STEP_W{1'b0}}) begin
            nextState_s   = ST_STEPPING;
            stepCntNext_s = cfgSteps;
          end else if (cfgFtw == {ACC_W{1'b0}}) begin
            nextState_s = ST_IDLE;
          end else begin
            nextState_s = ST_RUN;
          end
        end else begin
          nextState_s = state_r;
        end
      end
      ST_STEPPING: begin
        if (stepNow_s && (stepCnt_r == STEP_W'(1))) begin
          nextState_s = ST_RUN;
        end else begin
          nextState_s = ST_STEPPING;
        end
      end
      default: begin
        nextState_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered handshake/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      cfgReady_r <= 1'b1;
    end else begin
      state_r    <= nextState_s;
      busy_r     <= (nextState_s == ST_STEPPING);
      cfgReady_r <= (nextState_s != ST_STEPPING);
    end
  end

  // datapath; the step offset is captured with the tuning word at acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= {ACC_W{1'b0}};
      ftw_r       <= {ACC_W{1'b0}};
      phaseStep_r <= {ACC_W{1'b0}};
      stepCnt_r   <= {STEP_W{1'b0}};
      sigOut_r    <= 1'b0;
      stepEvent_r <= 1'b0;
    end else begin
      acc_r       <= accNext_s;
      stepCnt_r   <= stepCntNext_s;
      stepEvent_r <= stepNow_s;
      if (advance_s) begin
        sigOut_r <= acc_r[ACC_W-1];
      end else begin
        sigOut_r <= sigOut_r;
      end
      if (accept_s) begin
        ftw_r       <= cfgFtw;
        phaseStep_r <= cfgPhaseStep;
      end else begin
        ftw_r       <= ftw_r;
        phaseStep_r <= phaseStep_r;
      end
    end
  end

  assign sigOut    = sigOut_r;
  assign stepEvent = stepEvent_r;
  assign busy      = busy_r;
  assign cfgReady  = cfgReady_r;

endmodule

// File: tb/tb_ref_sig_gen.sv
// tb_ref_sig_gen: randomized self-checking bench for ref_sig_gen against a
// cycle-level arithmetic reference model (jitter macro undefined).
module tb_ref_sig_gen;

  localparam int     ACC_W  = 24;
  localparam int     STEP_W = 8;
  localparam longint MOD    = longint'(1) << ACC_W;

  logic              clk = 1'b0;
  logic              reset, enable, cfgValid, cfgReady;
  logic [ACC_W-1:0]  cfgFtw, cfgPhaseStep;
  logic [STEP_W-1:0] cfgSteps;
  logic              sigOut, stepEvent, busy;
  logic [3:0]        obs;

  int errors = 0;
  int checks = 0;

  // reference model: phase as a plain integer, steps pending as a count
  longint mAcc, mFtw, mPh;
  int     mLeft, mSync;
  bit     mSig, mEv, mAccepted;

  ref_sig_gen #(.ACC_W(ACC_W), .STEP_W(STEP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfgValid     (cfgValid),
    .cfgReady     (cfgReady),
    .cfgFtw       (cfgFtw),
    .cfgPhaseStep (cfgPhaseStep),
    .cfgSteps     (cfgSteps),
    .sigOut       (sigOut),
    .stepEvent    (stepEvent),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign obs = {sigOut, stepEvent, busy, cfgReady};

  function automatic logic [3:0] expVec();
    return {mSig, mEv, mLeft > 0, mLeft == 0};
  endfunction

  task automatic modelReset();
    mAcc = 0; mFtw = 0; mPh = 0; mLeft = 0; mSync = 0;
    mSig = 1'b0; mEv = 1'b0; mAccepted = 1'b0;
  endtask

  // one rising edge: advance the model from the inputs present at the edge
  task automatic cycle();
    bit     adv;
    longint s;
    mAccepted = (reset === 1'b1) && (cfgValid === 1'b1) && (mLeft == 0);
    adv       = (reset === 1'b1) && (enable === 1'b1) && (mSync >= 2);
    @(posedge clk);
    if (reset === 1'b1) begin
      mEv = 1'b0;
      if (adv) begin
        mSig = mAcc[ACC_W-1];
        s = mAcc + mFtw;
        if (s >= MOD && mLeft > 0) begin
          mAcc = (s + mPh) % MOD;
          mLeft = mLeft - 1;
          mEv = 1'b1;
        end else begin
          mAcc = s % MOD;
        end
      end
      if (mAccepted) begin
        mFtw = longint'(cfgFtw);
        mPh = longint'(cfgPhaseStep);
        mLeft = int'(cfgSteps);
      end
      if (mSync < 2) mSync = mSync + 1;
    end
    #1;
  endtask

  task automatic offer(input logic [ACC_W-1:0] f, input logic [ACC_W-1:0] p,
                       input logic [STEP_W-1:0] n);
    cfgFtw = f; cfgPhaseStep = p; cfgSteps = n; cfgValid = 1'b1;
    checks++;
    if (cfgReady !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready got=%b exp=1", cfgReady);
    end
    cycle();
    cfgValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cfgValid = 1'b0;
    cfgFtw = '0; cfgPhaseStep = '0; cfgSteps = '0;
    #2 reset = 1'b0;
    modelReset();
    #2;
    checks++;
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL reset_values got=%b exp=0001", obs);
    end
    cycle(); cycle();
    reset = 1'b1;
    offer(24'h800000, 24'h000000, 8'd0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, obs, expVec());
      end
    end
  endtask

  task automatic test_free_run();
    int lastRise, hi, periods, events;
    bit prev;
    offer(24'h100000, 24'h000000, 8'd0);
    lastRise = -1; hi = 0; periods = 0; events = 0; prev = sigOut;
    for (int k = 0; k < 80; k++) begin
      cycle();
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL free_run k=%0d got=%b exp=%b", k, obs, expVec());
      end
      if (stepEvent === 1'b1) events++;
      if (sigOut === 1'b1 && prev === 1'b0) begin
        if (lastRise >= 0) begin
          periods++;
          checks++;
          if (k - lastRise != 16 || hi != 8) begin
            errors++;
            $display("FAIL free_run_period got=%0d/%0d high exp=16/8", k - lastRise, hi);
          end
        end
        lastRise = k; hi = 0;
      end
      if (sigOut === 1'b1) hi++;
      prev = sigOut;
    end
    checks++;
    if (periods < 3 || events != 0) begin
      errors++;
      $display("FAIL free_run_summary got periods=%0d events=%0d exp >=3 and 0", periods, events);
    end
  endtask

  task automatic test_stepping();
    int pulses, last, k;
    bit gapOk;
    offer(24'h100000, 24'h080000, 8'd3);
    pulses = 0; last = -1; gapOk = 1'b1; k = 0;
    while (busy === 1'b1 && k < 300) begin
      cycle(); k++;
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL stepping k=%0d got=%b exp=%b", k, obs, expVec());
      end
      if (stepEvent === 1'b1) begin
        if (last >= 0 && k - last > 16) gapOk = 1'b0;
        last = k; pulses++;
      end
    end
    checks++;
    if (pulses != 3 || !gapOk) begin
      errors++;
      $display("FAIL stepping_pulses got=%0d consecutive=%b exp=3 consecutive=1", pulses, gapOk);
    end
    checks++;
    if (busy !== 1'b0 || cfgReady !== 1'b1) begin
      errors++;
      $display("FAIL stepping_done got busy=%b ready=%b exp 0 1", busy, cfgReady);
    end
  endtask

  task automatic test_hold_valid();
    int  pulses, k;
    bit  acceptedB, preReady;
    cfgFtw = 24'h100000; cfgPhaseStep = 24'hF80000; cfgSteps = 8'd2; cfgValid = 1'b1;
    cycle();
    cfgFtw = 24'h0C0000; cfgPhaseStep = 24'h010000; cfgSteps = 8'd1;
    pulses = 0; k = 0; acceptedB = 1'b0;
    while (!acceptedB && k < 400) begin
      preReady = cfgReady;
      cycle(); k++;
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL hold_valid k=%0d got=%b exp=%b", k, obs, expVec());
      end
      if (stepEvent === 1'b1) pulses++;
      if (mAccepted) begin
        acceptedB = 1'b1;
        checks++;
        if (preReady !== 1'b1) begin
          errors++;
          $display("FAIL hold_accept_ready got=%b exp=1", preReady);
        end
      end
    end
    cfgValid = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 400) begin
      cycle(); k++;
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL hold_valid_tail k=%0d got=%b exp=%b", k, obs, expVec());
      end
      if (stepEvent === 1'b1) pulses++;
    end
    checks++;
    if (!acceptedB || pulses != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_summary got accepted=%b pulses=%0d busy=%b exp 1 3 0", acceptedB, pulses, busy);
    end
  endtask

  task automatic test_enable_gap();
    int rises[$];
    bit prev, held;
    int span;
    offer(24'h100000, 24'h000000, 8'd0);
    prev = sigOut; held = 1'b0; span = -1;
    for (int k = 0; k < 64; k++) begin
      enable = !(k >= 20 && k < 25);
      cycle();
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL enable_gap k=%0d got=%b exp=%b", k, obs, expVec());
      end
      if (k == 19) held = sigOut;
      if (k >= 20 && k < 25) begin
        checks++;
        if (sigOut !== held) begin
          errors++;
          $display("FAIL enable_gap_hold k=%0d got=%b exp=%b", k, sigOut, held);
        end
      end
      if (sigOut === 1'b1 && prev === 1'b0) rises.push_back(k);
      prev = sigOut;
    end
    enable = 1'b1;
    for (int i = 0; i + 1 < rises.size(); i++) begin
      if (rises[i] < 20 && rises[i+1] >= 25) span = rises[i+1] - rises[i];
    end
    checks++;
    if (span != 21) begin
      errors++;
      $display("FAIL enable_gap_period got=%0d exp=21", span);
    end
  endtask

  task automatic test_reset_mid_step();
    int pulses, k;
    offer(24'h100000, 24'h040000, 8'd4);
    pulses = 0; k = 0;
    while (pulses < 2 && k < 300) begin
      cycle(); k++;
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL mid_step k=%0d got=%b exp=%b", k, obs, expVec());
      end
      if (stepEvent === 1'b1) pulses++;
    end
    #2 reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if (obs !== 4'b0001 || pulses != 2) begin
      errors++;
      $display("FAIL mid_step_reset got=%b pulses=%0d exp=0001 pulses=2", obs, pulses);
    end
    cycle(); cycle();
    reset = 1'b1;
    pulses = 0;
    for (int j = 0; j < 60; j++) begin
      cycle();
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL mid_step_after j=%0d got=%b exp=%b", j, obs, expVec());
      end
      if (stepEvent === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_step_no_event got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      enable = ($urandom_range(9, 0) != 0);
      if (cfgValid !== 1'b1 && $urandom_range(15, 0) == 0) begin
        cfgFtw = 24'($urandom_range(24'hFFFFFF, 24'h040000));
        cfgPhaseStep = 24'($urandom);
        cfgSteps = 8'($urandom_range(3, 0));
        if ($urandom_range(9, 0) == 0) begin
          cfgFtw = 24'h000000; cfgSteps = 8'd0;
        end
        cfgValid = 1'b1;
      end
      cycle();
      if (mAccepted) cfgValid = 1'b0;
      checks++;
      if (obs !== expVec()) begin
        errors++;
        $display("FAIL random k=%0d got=%b exp=%b", k, obs, expVec());
      end
    end
    enable = 1'b1; cfgValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stepping();
    test_hold_valid();
    test_enable_gap();
    test_reset_mid_step();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
